johnson_3bit: RTL and testbench

JOHNSON_3BIT -- requirements
Module: johnson_3bit

---
 rtl/johnson_pkg.sv | 30 +++
 rtl/seg7_decoder.sv | 23 ++
 rtl/johnson_3bit.sv | 50 +++++
 tb/tb_johnson_3bit.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/johnson_pkg.sv
// rtl/johnson_pkg.sv - shared constants and next-state rule for the 3-bit Johnson counter
package johnson_pkg;

  typedef logic [2:0] jstate_t;

  localparam jstate_t RESET_STATE = 3'b000;

  // Active-low segment patterns: bit0=a ... bit6=g, bit7=dp (kept dark)
  localparam logic [7:0] SEG_0    = 8'hC0;
  localparam logic [7:0] SEG_1    = 8'hF9;
  localparam logic [7:0] SEG_3    = 8'hB0;
  localparam logic [7:0] SEG_4    = 8'h99;
  localparam logic [7:0] SEG_6    = 8'h82;
  localparam logic [7:0] SEG_7    = 8'hF8;
  localparam logic [7:0] SEG_DASH = 8'hBF;

  // 010 and 101 form a second 2-cycle ring under the plain shift rule
  function automatic logic is_legal(input jstate_t s);
    return !((s == 3'b010) || (s == 3'b101));
  endfunction

  // Shift left with inverted MSB into LSB; illegal states fall back to reset
  function automatic jstate_t johnson_next(input jstate_t s);
    if (!is_legal(s)) begin
      return RESET_STATE;
    end
    return {s[1:0], ~s[2]};
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - octal digit decode of a Johnson state onto active-low segments
module seg7_decoder
  import johnson_pkg::*;
(
  input  logic [2:0] value,
  output logic [7:0] seg
);

  // Legal Johnson states show their octal value; the two illegal ones show a dash
  always_comb begin
    seg = SEG_DASH;
    case (value)
      3'b000:  seg = SEG_0;
      3'b001:  seg = SEG_1;
      3'b011:  seg = SEG_3;
      3'b111:  seg = SEG_7;
      3'b110:  seg = SEG_6;
      3'b100:  seg = SEG_4;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/johnson_3bit.sv
// rtl/johnson_3bit.sv - prescaled self-correcting 3-bit Johnson counter with 7-segment readout
module johnson_3bit
  import johnson_pkg::*;
#(
  parameter int unsigned DIV = 1
) (
  input  logic       inClk,
  input  logic       rst,
  output logic [2:0] cntr,
  output logic [7:0] Seven_Seg
);

  // DIV=1 still needs a 1-bit prescaler that simply sits at zero
  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  logic [PW-1:0] pre_cnt;
  logic          step_en;
  jstate_t       cntr_q;

  assign step_en = (pre_cnt == PRE_LAST);

  // Prescaler: count 0..DIV-1, wrapping on the step cycle
  always_ff @(posedge inClk or negedge rst) begin
    if (!rst) begin
      pre_cnt <= '0;
    end else if (step_en) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PW'(1);
    end
  end

  // Johnson shift register: advance only on step cycles, otherwise hold
  always_ff @(posedge inClk or negedge rst) begin
    if (!rst) begin
      cntr_q <= RESET_STATE;
    end else if (step_en) begin
      cntr_q <= johnson_next(cntr_q);
    end
  end

  assign cntr = cntr_q;

  seg7_decoder u_seg7_decoder (
    .value (cntr_q),
    .seg   (Seven_Seg)
  );

endmodule

// File: tb/tb_johnson_3bit.sv
// tb/tb_johnson_3bit.sv - self-checking bench for johnson_3bit (DIV=1 and DIV=4)
module tb_johnson_3bit;

  logic       inClk = 1'b0;
  logic       rst   = 1'b0;
  logic [2:0] cntr1, cntr4;
  logic [7:0] seg1, seg4;

  int compared   = 0;
  int mismatched = 0;
  int edges      = 0;
  logic check_en = 1'b0;

  // Expected display sequence from reset: step k shows ring[k % 6]
  logic [2:0] ring_val [6] = '{3'b000, 3'b001, 3'b011, 3'b111, 3'b110, 3'b100};
  logic [7:0] ring_seg [6] = '{8'hC0, 8'hF9, 8'hB0, 8'hF8, 8'h82, 8'h99};

  // Hand-computed values after edges 1..12 following reset release
  logic [2:0] lit_div1 [12] = '{3'b001, 3'b011, 3'b111, 3'b110, 3'b100, 3'b000,
                                3'b001, 3'b011, 3'b111, 3'b110, 3'b100, 3'b000};
  logic [7:0] lit_seg1 [12] = '{8'hF9, 8'hB0, 8'hF8, 8'h82, 8'h99, 8'hC0,
                                8'hF9, 8'hB0, 8'hF8, 8'h82, 8'h99, 8'hC0};
  logic [2:0] lit_div4 [12] = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b001, 3'b001,
                                3'b001, 3'b011, 3'b011, 3'b011, 3'b011, 3'b111};

  johnson_3bit #(.DIV(1)) dut (
    .inClk     (inClk),
    .rst       (rst),
    .cntr      (cntr1),
    .Seven_Seg (seg1)
  );

  johnson_3bit #(.DIV(4)) dut4 (
    .inClk     (inClk),
    .rst       (rst),
    .cntr      (cntr4),
    .Seven_Seg (seg4)
  );

  always #5 inClk = ~inClk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %02h expected %02h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: rising edges seen since reset release
  always @(posedge inClk or negedge rst) begin
    if (!rst) edges <= 0;
    else      edges <= edges + 1;
  end

  // Continuous comparison against the model, away from the active edge
  always @(negedge inClk) begin
    if (check_en) begin
      if (!rst) begin
        chk("model_rst_cntr1", {5'b0, cntr1}, 8'h00);
        chk("model_rst_seg1", seg1, 8'hC0);
        chk("model_rst_cntr4", {5'b0, cntr4}, 8'h00);
        chk("model_rst_seg4", seg4, 8'hC0);
      end else begin
        chk("model_cntr1", {5'b0, cntr1}, {5'b0, ring_val[edges % 6]});
        chk("model_seg1", seg1, ring_seg[edges % 6]);
        chk("model_cntr4", {5'b0, cntr4}, {5'b0, ring_val[(edges / 4) % 6]});
        chk("model_seg4", seg4, ring_seg[(edges / 4) % 6]);
      end
    end
  end

  initial begin
    bit found;

    // Reset held with clock running
    #1;
    chk("reset_cntr_t1", {5'b0, cntr1}, 8'h00);
    chk("reset_seg_t1", seg1, 8'hC0);
    check_en = 1'b1;
    repeat (2) @(negedge inClk);
    #1;
    chk("reset_cntr_held", {5'b0, cntr1}, 8'h00);
    chk("reset_seg_held", seg1, 8'hC0);
    chk("reset_cntr4_held", {5'b0, cntr4}, 8'h00);

    // Release and walk 12 edges against literal expectations
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge inClk);
      #1;
      chk($sformatf("seq_cntr_e%0d", i + 1), {5'b0, cntr1}, {5'b0, lit_div1[i]});
      chk($sformatf("seq_seg_e%0d", i + 1), seg1, lit_seg1[i]);
      chk($sformatf("div4_cntr_e%0d", i + 1), {5'b0, cntr4}, {5'b0, lit_div4[i]});
    end

    // Long run covered by the model comparison
    repeat (100) @(posedge inClk);

    // Asynchronous reset while showing 111
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(posedge inClk);
      #2;
      if (cntr1 == 3'b111) found = 1'b1;
    end
    chk("async_found_111", {7'b0, found}, 8'h01);
    rst = 1'b0;
    #1;
    chk("async_cntr", {5'b0, cntr1}, 8'h00);
    chk("async_seg", seg1, 8'hC0);
    @(negedge inClk);
    #1;
    rst = 1'b1;
    repeat (8) @(posedge inClk);

    // Illegal state: forced 010 shows a dash, then recovers to 000
    @(negedge inClk);
    #1;
    check_en = 1'b0;
    force dut.cntr_q = 3'b010;
    #1;
    chk("illegal_cntr_forced", {5'b0, cntr1}, 8'h02);
    chk("illegal_seg_dash", seg1, 8'hBF);
    release dut.cntr_q;
    @(posedge inClk);
    #1;
    chk("illegal_recover_cntr", {5'b0, cntr1}, 8'h00);
    chk("illegal_recover_seg", seg1, 8'hC0);

    // Resynchronise both instances with the model and run on
    rst = 1'b0;
    @(negedge inClk);
    #1;
    rst = 1'b1;
    check_en = 1'b1;
    repeat (30) @(posedge inClk);
    @(negedge inClk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
